vga_fb_scanout: RTL and testbench

VGA_FB_SCANOUT -- requirements
Module: vga_fb_scanout

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing.sv | 67 ++++++
 rtl/vga_fb_scanout.sv | 163 ++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the colour-channel expansion helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Right-aligned 'bits'-wide channel in c is replicated MSB-first across 8 output bits.
  function automatic logic [7:0] expand_chan(input logic [7:0] c, input int unsigned bits);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[3'(7 - i)] = c[3'(bits - 1 - (i % bits))];
    end
    return o;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync, visible and frame-end decode.
module vga_timing import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          pix_en_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          visible_o,
  output logic          hs_act_o,
  output logic          vs_act_o,
  output logic          frame_end_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  assign h_last = (h_cnt_q == HW'(HTotal - 1));
  assign v_last = (v_cnt_q == VW'(VTotal - 1));

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign visible_o   = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
  assign hs_act_o    = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                       (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_act_o    = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                       (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/vga_fb_scanout.sv
// Frame-buffer scan-out: address generation, 3-stage pipeline, buffer flip and colour.
module vga_fb_scanout import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CBITS    = 4,
  parameter int unsigned IMG_WB   = 9,
  parameter int unsigned IMG_HB   = 8,
  parameter int unsigned SCALE    = 0,
  parameter logic [23:0] BG       = 24'h000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_en,
  input  logic                     buf_sel,
  output logic [IMG_HB+IMG_WB:0]   fb_addr,
  input  logic [3*CBITS-1:0]       fb_rdata,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     blank_n,
  output logic [7:0]               vga_r,
  output logic [7:0]               vga_g,
  output logic [7:0]               vga_b,
  output logic [9:0]               h_addr,
  output logic [9:0]               v_addr,
  output logic                     frame_start,
  output logic                     cur_buf
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned ImgW   = (32'd1 << IMG_WB) << SCALE;
  localparam int unsigned ImgH   = (32'd1 << IMG_HB) << SCALE;
  localparam int unsigned AW     = 1 + IMG_HB + IMG_WB;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          visible, hs_act, vs_act, frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk_i       (clk),
    .reset_i     (reset),
    .pix_en_i    (pix_en),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .visible_o   (visible),
    .hs_act_o    (hs_act),
    .vs_act_o    (vs_act),
    .frame_end_o (frame_end)
  );

  logic [IMG_WB-1:0] x_fld;
  logic [IMG_HB-1:0] y_fld;
  logic              in_img;
  logic [AW-1:0]     addr_d;
  logic              first_d;
  logic [23:0]       rgb_d;

  // Stage 2: address plus flags delayed to match the read.
  logic [AW-1:0] addr_q;
  logic          vis2_q, img2_q, hs2_q, vs2_q, first2_q;
  logic [9:0]    h2_q, v2_q;
  // Stage 3: pin registers.
  logic          blank3_q, hs3_q, vs3_q, fs_q;
  logic [23:0]   rgb3_q;
  logic [9:0]    h3_q, v3_q;
  logic          cur_buf_q;

  assign x_fld   = IMG_WB'(32'(h_cnt) >> SCALE);
  assign y_fld   = IMG_HB'(32'(v_cnt) >> SCALE);
  assign in_img  = visible && (32'(h_cnt) < ImgW) && (32'(v_cnt) < ImgH);
  assign addr_d  = {cur_buf_q, y_fld, x_fld};
  assign first_d = (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    rgb_d = '0;
    if (vis2_q) begin
      if (img2_q) begin
        rgb_d = {expand_chan(8'(fb_rdata[3*CBITS-1 -: CBITS]), CBITS),
                 expand_chan(8'(fb_rdata[2*CBITS-1 -: CBITS]), CBITS),
                 expand_chan(8'(fb_rdata[CBITS-1:0]), CBITS)};
      end else begin
        rgb_d = BG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      vis2_q    <= 1'b0;
      img2_q    <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      first2_q  <= 1'b0;
      h2_q      <= '0;
      v2_q      <= '0;
      blank3_q  <= 1'b0;
      hs3_q     <= 1'b0;
      vs3_q     <= 1'b0;
      fs_q      <= 1'b0;
      rgb3_q    <= '0;
      h3_q      <= '0;
      v3_q      <= '0;
      cur_buf_q <= 1'b0;
    end else begin
      // Single-clk pulse even when ticks are spaced further apart.
      fs_q <= pix_en & first2_q;
      if (pix_en) begin
        addr_q   <= addr_d;
        vis2_q   <= visible;
        img2_q   <= in_img;
        hs2_q    <= hs_act;
        vs2_q    <= vs_act;
        first2_q <= first_d;
        h2_q     <= 10'(h_cnt);
        v2_q     <= 10'(v_cnt);
        blank3_q <= vis2_q;
        hs3_q    <= hs2_q;
        vs3_q    <= vs2_q;
        rgb3_q   <= rgb_d;
        h3_q     <= h2_q;
        v3_q     <= v2_q;
        if (frame_end) begin
          cur_buf_q <= buf_sel;
        end
      end
    end
  end

  assign fb_addr     = addr_q;
  assign hsync       = hs3_q ? HS_POL : ~HS_POL;
  assign vsync       = vs3_q ? VS_POL : ~VS_POL;
  assign blank_n     = blank3_q;
  assign vga_r       = rgb3_q[23:16];
  assign vga_g       = rgb3_q[15:8];
  assign vga_b       = rgb3_q[7:0];
  assign h_addr      = h3_q;
  assign v_addr      = v3_q;
  assign frame_start = fs_q;
  assign cur_buf     = cur_buf_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Randomized bench for vga_fb_scanout against a pixel-index reference model.
module tb_vga_fb_scanout;

  localparam int unsigned HA = 24, HF = 3, HS = 4, HB = 5;
  localparam int unsigned VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned CB = 4, IWB = 3, IHB = 2, SC = 1;
  localparam int unsigned IMGW = (1 << IWB) * (1 << SC);
  localparam int unsigned IMGH = (1 << IHB) * (1 << SC);
  localparam bit          HPOL = 1'b0, VPOL = 1'b1;
  localparam logic [23:0] BGC = 24'h123456;
  localparam int unsigned AW = 1 + IHB + IWB;

  logic          clk = 1'b0;
  logic          reset = 1'b1, pix_en = 1'b0, buf_sel = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [11:0]   fb_rdata;
  logic          hsync, vsync, blank_n, frame_start, cur_buf;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic [9:0]    h_addr, v_addr;

  logic [11:0]   mem [64];
  assign fb_rdata = mem[fb_addr];

  always #5 clk = ~clk;

  vga_fb_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (HPOL), .VS_POL (VPOL),
    .CBITS    (CB), .IMG_WB (IWB), .IMG_HB (IHB), .SCALE (SC),
    .BG       (BGC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .buf_sel     (buf_sel),
    .fb_addr     (fb_addr),
    .fb_rdata    (fb_rdata),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .h_addr      (h_addr),
    .v_addr      (v_addr),
    .frame_start (frame_start),
    .cur_buf     (cur_buf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;   // pix_en ticks since reset release
  bit tick    = 1'b0;
  bit bufh [64];     // buffer shown in each frame since reset
  bit cur_bs  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at tick %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int p);
    int pos = p % FT;
    int h   = pos % HT;
    int v   = pos / HT;
    int x   = (h / (1 << SC)) % (1 << IWB);
    int y   = (v / (1 << SC)) % (1 << IHB);
    int b   = int'(bufh[p / FT]);
    return AW'(b * (1 << (IHB + IWB)) + y * (1 << IWB) + x);
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] ea;
    logic [2:0]    es;
    logic [23:0]   ergb;
    logic [19:0]   ec;
    logic          efs;
    logic [11:0]   w;
    int            p, pos, h, v;
    bit            vis, img;
    ea   = (k == 0) ? '0 : addr_of(k - 1);
    es   = {~HPOL, ~VPOL, 1'b0};
    ergb = '0;
    ec   = '0;
    efs  = 1'b0;
    if (k >= 2) begin
      p   = k - 2;
      pos = p % FT;
      h   = pos % HT;
      v   = pos / HT;
      vis = (h < HA) && (v < VA);
      img = vis && (h < IMGW) && (v < IMGH);
      es  = {(h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL,
             (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL,
             vis};
      w   = mem[addr_of(p)];
      if (img) ergb = {w[11:8], w[11:8], w[7:4], w[7:4], w[3:0], w[3:0]};
      else if (vis) ergb = BGC;
      ec  = {10'(h), 10'(v)};
      efs = tick && (pos == 0);
    end
    check_eq("cur_buf", 32'(cur_buf), 32'(bufh[k / FT]));
    check_eq("fb_addr", 32'(fb_addr), 32'(ea));
    check_eq("sync_blank", 32'({hsync, vsync, blank_n}), 32'(es));
    check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(ergb));
    check_eq("coord", 32'({h_addr, v_addr}), 32'(ec));
    check_eq("frame_start", 32'(frame_start), 32'(efs));
  endtask

  task automatic step(input bit rst, input bit pe, input bit bs);
    @(negedge clk);
    reset   = rst;
    pix_en  = pe;
    buf_sel = bs;
    @(posedge clk);
    tick = 1'b0;
    if (rst) begin
      k = 0;
      foreach (bufh[i]) bufh[i] = 1'b0;
    end else if (pe) begin
      if (k % FT == FT - 1) bufh[k / FT + 1] = bs;
      k++;
      tick = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int hs_cnt = 0, vs_cnt = 0, bl_cnt = 0, fs_cnt = 0;
    foreach (mem[i]) mem[i] = 12'($urandom);
    mem[9] = 12'hA5F;  // buf 0, y=1, x=1 -> screen pixels (2..3, 2..3)
    foreach (bufh[i]) bufh[i] = 1'b0;

    // Reset held 3 clks with pix_en high.
    repeat (3) step(1'b1, 1'b1, 1'b0);

    // Continuous ticks; flip buffer request at line 5 of frame 0.
    while (k < 2 * int'(FT) + 4) begin
      if (k == 5 * int'(HT)) cur_bs = 1'b1;
      step(1'b0, 1'b1, cur_bs);
      if (k >= 2 && k - 2 < int'(FT)) begin
        hs_cnt += (hsync == HPOL) ? 1 : 0;
        vs_cnt += (vsync == VPOL) ? 1 : 0;
        bl_cnt += blank_n ? 1 : 0;
      end
      if (k >= 2 && k - 2 < 2 * int'(FT)) fs_cnt += frame_start ? 1 : 0;
      if (k == 2 * int'(HT) + 4) check_eq("a5f_expand", 32'({vga_r, vga_g, vga_b}), 32'h00AA55FF);
    end
    check_eq("hsync_ticks", 32'(hs_cnt), 32'(HS * VT));
    check_eq("vsync_ticks", 32'(vs_cnt), 32'(VS * HT));
    check_eq("blank_ticks", 32'(bl_cnt), 32'(HA * VA));
    check_eq("frame_pulses", 32'(fs_cnt), 32'd2);

    // Random tick spacing and random buffer requests.
    repeat (3 * FT * 3 / 2) begin
      if ($urandom_range(0, 99) < 3) cur_bs = ~cur_bs;
      step(1'b0, $urandom_range(0, 2) != 0, cur_bs);
    end

    // Mid-frame reset, then a tick every 4th clk.
    step(1'b1, 1'($urandom), cur_bs);
    step(1'b1, 1'($urandom), cur_bs);
    for (int c = 0; c < 4 * (int'(FT) + 12); c++) begin
      if ($urandom_range(0, 199) == 0) cur_bs = ~cur_bs;
      step(1'b0, (c % 4) == 3, cur_bs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
